// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Brief    : Shared FSM state type and default timing constants for the
//            push-button debounce/pulse stage.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // 20 ms hold at 50 MHz; auto-repeat 500 ms first delay, then every 100 ms
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 5000000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_cell
// Brief    : One key channel: 2-flop synchroniser, hold-time debounce FSM,
//            registered level/press/release. KEY_AUTOREPEAT_EN adds repeats.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic             w_s;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_press_acc;
  logic             w_release_nxt;
  logic             w_rpt_fire;

  assign w_s = ~r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_acc | w_rpt_fire;
      r_release <= w_release_nxt;
    end
  end

  // The counter is cleared on every state change, so it never passes c_cnt_max
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_acc   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_acc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] c_delay_max  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_period_max = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rpt;
  logic             r_armed;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic             w_armed_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_rpt   <= w_rpt_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // RELEASE_WAIT holds the count so a release bounce resumes the repeat timing
  always_comb begin
    w_rpt_nxt   = r_rpt;
    w_armed_nxt = r_armed;
    w_rpt_fire  = 1'b0;
    if (r_state == RELEASED || r_state == PRESS_WAIT) begin
      w_rpt_nxt   = '0;
      w_armed_nxt = 1'b0;
    end else if (r_state == PRESSED && w_s) begin
      if (r_rpt == (r_armed ? c_period_max : c_delay_max)) begin
        w_rpt_fire  = 1'b1;
        w_rpt_nxt   = '0;
        w_armed_nxt = 1'b1;
      end else begin
        w_rpt_nxt = r_rpt + 1'b1;
      end
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rpt_fire   = 1'b0;
`endif

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse
// Brief    : NUM_KEYS independent debounce/pulse channels for active-low keys.
//            Optional auto-repeat via KEY_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_cell (
      .clk         (CLOCK_50),
      .rst_n       (reset_n),
      .key_n       (key_n[gi]),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi])
    );
  end

endmodule
`default_nettype wire
